// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter for one shared resource.
// The winner is reported both as a 3-bit index and as a one-hot grant
// built by an enable-gated 3-to-8 decode. Ownership is bounded by a hold
// limit when others are waiting, and every grant is followed by one dead cycle.
`timescale 1ns/1ps

module rr_decode_arbiter #(
    parameter int NREQ     = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx,
    output logic            gnt_valid,
    output logic            preempt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Last hcnt value an owner may reach before it must yield to a waiter.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      hcnt_q, hcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            preempt_q, preempt_d;

    logic [2:0]      win_idx;
    logic            win_found;
    logic [2:0]      cand;
    logic [NREQ-1:0] owner_mask;
    logic            others_waiting;

    // 3-to-8 decode; a low enable forces an all-zero vector.
    function automatic logic [NREQ-1:0] decode3to8(input logic [2:0] idx, input logic ena);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        if (ena) begin
            onehot[idx] = 1'b1;
        end
        return onehot;
    endfunction

    // Rotated priority search: first requester at or after the pointer wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Requests from anyone other than the current owner.
    always_comb begin
        owner_mask     = decode3to8(idx_q, 1'b1);
        others_waiting = |(req & ~owner_mask);
    end

    // Next-state logic for the IDLE / GRANT / GAP controller.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (en && win_found) begin
                    idx_d   = win_idx;
                    gnt_d   = decode3to8(win_idx, 1'b1);
                    valid_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = ST_GRANT;
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    state_d = ST_IDLE;
                end else if (!req[idx_q]) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    state_d = ST_GAP;
                end else if (hcnt_q == HOLD_LAST && others_waiting) begin
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    preempt_d = 1'b1;
                    ptr_d     = idx_q + 3'd1;
                    state_d   = ST_GAP;
                end else if (hcnt_q != HOLD_LAST) begin
                    // A lone owner saturates here and keeps the grant.
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over enable and requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Testbench for rr_decode_arbiter (MAX_HOLD=4): a table of directed vectors
// with hand-computed outputs, then hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    rr_decode_arbiter #(.NREQ(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [7:0] rq,
                       input logic [7:0] g, input logic [2:0] ix,
                       input logic v, input logic p);
        vec_t t;
        t.rst = r; t.en = e; t.req = rq; t.gnt = g; t.idx = ix; t.valid = v; t.pre = p;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, actual, expected);
        end
    endtask

    // Apply inputs, clock once, and let the outputs settle past the edge.
    task automatic step(input logic r, input logic e, input logic [7:0] rq);
        rst = r; en = e; req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] ix,
                             input logic v, input logic p);
        check({tag, ".gnt"}, gnt, g);
        check({tag, ".idx"}, 8'(gnt_idx), 8'(ix));
        check({tag, ".valid"}, 8'(gnt_valid), 8'(v));
        check({tag, ".preempt"}, 8'(preempt), 8'(p));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'h00;

        //  rst en  req    gnt    idx v p
        // Reset with every request up, then first grant to 0.
        add(1, 1, 8'hFF, 8'h00, 0, 0, 0);
        add(1, 1, 8'hFF, 8'h00, 0, 0, 0);
        add(0, 1, 8'hFF, 8'h01, 0, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);   // release -> GAP, ptr=1
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);   // GAP -> IDLE
        // Round robin over 2,5,7,2; each owner drops its bit after 3 cycles.
        add(0, 1, 8'hA4, 8'h04, 2, 1, 0);
        add(0, 1, 8'hA4, 8'h04, 2, 1, 0);
        add(0, 1, 8'hA4, 8'h04, 2, 1, 0);
        add(0, 1, 8'hA0, 8'h00, 2, 0, 0);   // release; others wait through GAP
        add(0, 1, 8'hA4, 8'h20, 5, 1, 0);
        add(0, 1, 8'hA4, 8'h20, 5, 1, 0);
        add(0, 1, 8'hA4, 8'h20, 5, 1, 0);
        add(0, 1, 8'h84, 8'h00, 5, 0, 0);
        add(0, 1, 8'hA4, 8'h80, 7, 1, 0);
        add(0, 1, 8'hA4, 8'h80, 7, 1, 0);
        add(0, 1, 8'hA4, 8'h80, 7, 1, 0);
        add(0, 1, 8'h24, 8'h00, 7, 0, 0);   // ptr wraps to 0
        add(0, 1, 8'hA4, 8'h04, 2, 1, 0);
        add(0, 1, 8'h00, 8'h00, 2, 0, 0);   // ptr=3
        add(0, 1, 8'h00, 8'h00, 2, 0, 0);
        // Hold limit: owner 3 keeps 4 cycles, then preempted in favour of 6.
        add(0, 1, 8'h08, 8'h08, 3, 1, 0);
        add(0, 1, 8'h48, 8'h08, 3, 1, 0);
        add(0, 1, 8'h48, 8'h08, 3, 1, 0);
        add(0, 1, 8'h48, 8'h08, 3, 1, 0);
        add(0, 1, 8'h48, 8'h00, 3, 0, 1);
        add(0, 1, 8'h48, 8'h40, 6, 1, 0);
        add(0, 1, 8'h00, 8'h00, 6, 0, 0);   // ptr=7
        add(0, 1, 8'h00, 8'h00, 6, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req);
            check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].pre);
        end

        // Solo owner: no competitor, so the hold limit never fires.
        for (int c = 0; c < 20; c++) begin
            step(0, 1, 8'h02);
            check($sformatf("solo%0d.gnt", c), gnt, 8'h02);
            check($sformatf("solo%0d.preempt", c), 8'(preempt), 8'h00);
        end
        step(0, 1, 8'h00);                    // release, ptr=2
        check_all("solo_rel", 8'h00, 1, 0, 0);
        step(0, 1, 8'h00);

        // Enable abort while owner 4 holds the grant.
        step(0, 1, 8'h10);
        check_all("abort_own", 8'h10, 4, 1, 0);
        step(0, 0, 8'h11);
        check_all("abort_drop", 8'h00, 4, 0, 0);
        step(0, 0, 8'h11);
        check_all("abort_blocked", 8'h00, 4, 0, 0);
        step(0, 1, 8'h11);                    // ptr=5 wraps round to 0
        check_all("abort_resume", 8'h01, 0, 1, 0);

        // Wrap-around: owner 7 releases while 0 waits; 0 wins after GAP.
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h80);
        check_all("wrap_own7", 8'h80, 7, 1, 0);
        step(0, 1, 8'h01);
        check_all("wrap_gap", 8'h00, 7, 0, 0);
        step(0, 1, 8'h81);
        check_all("wrap_to0", 8'h01, 0, 1, 0);

        // Reset mid-grant drops the grant at that edge and clears the pointer.
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h20);
        check_all("rst_own5", 8'h20, 5, 1, 0);
        step(1, 1, 8'h20);
        check_all("rst_mid", 8'h00, 0, 0, 0);
        step(0, 1, 8'hFF);
        check_all("rst_after", 8'h01, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
